// File: rtl/cgra_batch_pkg.sv
// ----------------------------------------------------------------------------
// cgra_batch_pkg
// Shared definitions for the CGRA batch sequencer:
//   state_e      - sequencer states (IDLE, LOAD, RUN, RELEASE, UNLOAD)
//   word_to_byte - converts a word index into a BRAM byte address
// ----------------------------------------------------------------------------
package cgra_batch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_UNLOAD  = 3'd4
    } state_e;

    // Working width of the address helper; callers cast to their port width.
    localparam int ADDR_CALC_W = 32;

    // BYTE_LEN is a power of two, so the byte address is a left shift by
    // log2(BYTE_LEN).
    function automatic logic [ADDR_CALC_W-1:0] word_to_byte(
        input logic [ADDR_CALC_W-1:0] word_idx,
        input int unsigned            shift
    );
        return word_idx << shift;
    endfunction

endpackage

// File: rtl/cgra_fifo2.sv
// ----------------------------------------------------------------------------
// cgra_fifo2
// Two-entry synchronous FIFO with valid/ready on both sides.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : write handshake, in_data is the pushed word
//   out_valid/out_ready   : read handshake, out_data is the head word
// The head word holds while out_valid & !out_ready.
// ----------------------------------------------------------------------------
module cgra_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: rtl/cgra_batch_ctrl.sv
// ----------------------------------------------------------------------------
// cgra_batch_ctrl
// Host-side sequencer for the CGRA: loads a batch into the data BRAM, runs
// the Computation_Start/Computation_Done handshake, then streams the result
// window back out of the BRAM.
//   Clk, Resetn                : clock, asynchronous active-low reset
//   Cfg_Start/Cfg_*            : batch request and its sizes (latched on accept)
//   In_Valid/In_Ready/In_Data  : input word stream, written to words 0..N-1
//   Out_Valid/Out_Ready/Out_Data/Out_Last : result word stream
//   Mem_En/Mem_Wen/Mem_Addr/Mem_Dout/Mem_Din : BRAM port (1-cycle read latency)
//   Computation_Start/Computation_Done     : CGRA level handshake
//   Busy, Timeout_Err          : status; Timeout_Err sticky until next accept
// ----------------------------------------------------------------------------
module cgra_batch_ctrl
    import cgra_batch_pkg::*;
#(
    parameter int SYS_DWIDTH   = 32,
    parameter int BYTE_LEN     = 4,
    parameter int AWIDTH       = 12,
    parameter int DONE_TIMEOUT = 65535
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  Cfg_Start,
    input  logic [AWIDTH:0]       Cfg_In_Words,
    input  logic [AWIDTH-1:0]     Cfg_Out_Base,
    input  logic [AWIDTH:0]       Cfg_Out_Words,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [SYS_DWIDTH-1:0] In_Data,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [SYS_DWIDTH-1:0] Out_Data,
    output logic                  Out_Last,
    output logic                  Mem_En,
    output logic [BYTE_LEN-1:0]   Mem_Wen,
    output logic [SYS_DWIDTH-1:0] Mem_Addr,
    output logic [SYS_DWIDTH-1:0] Mem_Dout,
    input  logic [SYS_DWIDTH-1:0] Mem_Din,
    output logic                  Computation_Start,
    input  logic                  Computation_Done,
    output logic                  Busy,
    output logic                  Timeout_Err
);

    localparam int unsigned  ADDR_SHIFT = $clog2(BYTE_LEN);
    localparam int           TW         = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(DONE_TIMEOUT - 1);
    localparam logic [AWIDTH:0] ONE_W   = 1;

    state_e              state_q, state_d;
    logic [AWIDTH:0]     in_words_q, out_words_q;
    logic [AWIDTH-1:0]   out_base_q;
    logic [AWIDTH:0]     idx_q;       // load beats written
    logic [AWIDTH:0]     rd_k_q;      // unload reads issued
    logic [AWIDTH:0]     out_k_q;     // unload beats accepted
    logic [TW-1:0]       to_cnt_q;
    logic                timeout_err_q;
    logic                rd_vld_p1;   // read issued last cycle, Mem_Din valid now

    logic                accept, load_beat, issue, pop, timeout_hit;
    logic                fifo_in_ready, fifo_out_valid;
    logic [SYS_DWIDTH-1:0] fifo_out_data;
    logic [2:0]          occ_after_pop;
    logic [AWIDTH-1:0]   addr_word;

    assign accept      = (state_q == ST_IDLE) && Cfg_Start;
    assign load_beat   = (state_q == ST_LOAD) && In_Valid;
    assign timeout_hit = (state_q == ST_RUN) && !Computation_Done && (to_cnt_q == TO_LAST);
    assign pop         = (state_q == ST_UNLOAD) && fifo_out_valid && Out_Ready;

    // Occupancy counts the FIFO after this cycle's pop plus the read landing
    // next cycle; a new read is allowed only while that stays below two, so
    // the FIFO can never be overrun yet sustains one word per cycle.
    assign occ_after_pop = 3'(fifo_out_valid) + 3'(!fifo_in_ready)
                         + 3'(rd_vld_p1) - 3'(pop);
    assign issue = (state_q == ST_UNLOAD) && (rd_k_q < out_words_q)
                 && (occ_after_pop < 3'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (Cfg_Start) state_d = (Cfg_In_Words == '0) ? ST_RUN : ST_LOAD;
            ST_LOAD:    if (In_Valid && (idx_q == in_words_q - ONE_W)) state_d = ST_RUN;
            ST_RUN: begin
                if (Computation_Done)  state_d = ST_RELEASE;
                else if (timeout_hit)  state_d = ST_IDLE;
            end
            ST_RELEASE: if (!Computation_Done)
                            state_d = (out_words_q == '0) ? ST_IDLE : ST_UNLOAD;
            ST_UNLOAD:  if (pop && (out_k_q == out_words_q - ONE_W)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            rd_k_q        <= '0;
            out_k_q       <= '0;
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
            rd_vld_p1     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q         <= '0;
                rd_k_q        <= '0;
                out_k_q       <= '0;
                timeout_err_q <= 1'b0;
            end else begin
                if (load_beat)   idx_q         <= idx_q + ONE_W;
                if (issue)       rd_k_q        <= rd_k_q + ONE_W;
                if (pop)         out_k_q       <= out_k_q + ONE_W;
                if (timeout_hit) timeout_err_q <= 1'b1;
            end
            // Held at zero outside RUN, so every RUN entry starts a fresh count.
            to_cnt_q  <= (state_q == ST_RUN) ? to_cnt_q + TW'(1) : '0;
            // ---- read stage p0 -> p1: BRAM returns Mem_Din one cycle later ----
            rd_vld_p1 <= issue;
        end
    end

    // Batch configuration is plain data captured on accept.
    always_ff @(posedge Clk) begin
        if (accept) begin
            in_words_q  <= Cfg_In_Words;
            out_base_q  <= Cfg_Out_Base;
            out_words_q <= Cfg_Out_Words;
        end
    end

    // ---- read stage p1: capture returning word into the output FIFO ----
    cgra_fifo2 #(.DATA_W(SYS_DWIDTH)) u_fifo (
        .clk       (Clk),
        .rst_n     (Resetn),
        .in_valid  (rd_vld_p1),
        .in_ready  (fifo_in_ready),
        .in_data   (Mem_Din),
        .out_valid (fifo_out_valid),
        .out_ready (pop),
        .out_data  (fifo_out_data)
    );

    // Result window index wraps naturally in the AWIDTH-bit sum.
    assign addr_word = load_beat ? idx_q[AWIDTH-1:0]
                                 : out_base_q + rd_k_q[AWIDTH-1:0];

    always_comb begin
        In_Ready          = (state_q == ST_LOAD);
        Mem_En            = load_beat | issue;
        Mem_Wen           = load_beat ? '1 : '0;
        Mem_Addr          = Mem_En ? SYS_DWIDTH'(word_to_byte(ADDR_CALC_W'(addr_word), ADDR_SHIFT))
                                   : '0;
        Mem_Dout          = load_beat ? In_Data : '0;
        Computation_Start = (state_q == ST_RUN);
        Busy              = (state_q != ST_IDLE);
        Timeout_Err       = timeout_err_q;
        Out_Valid         = (state_q == ST_UNLOAD) && fifo_out_valid;
        Out_Data          = Out_Valid ? fifo_out_data : '0;
        Out_Last          = Out_Valid && (out_k_q == out_words_q - ONE_W);
    end

endmodule

// File: tb/tb_cgra_batch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cgra_batch_ctrl
// Directed bench for cgra_batch_ctrl with a behavioural 1-cycle-latency BRAM.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit
// later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_cgra_batch_ctrl;

  localparam int SYS_DWIDTH   = 32;
  localparam int BYTE_LEN     = 4;
  localparam int AWIDTH       = 12;
  localparam int DONE_TIMEOUT = 20;

  logic                  Clk;
  logic                  Resetn;
  logic                  Cfg_Start;
  logic [AWIDTH:0]       Cfg_In_Words;
  logic [AWIDTH-1:0]     Cfg_Out_Base;
  logic [AWIDTH:0]       Cfg_Out_Words;
  logic                  In_Valid;
  logic                  In_Ready;
  logic [SYS_DWIDTH-1:0] In_Data;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic [SYS_DWIDTH-1:0] Out_Data;
  logic                  Out_Last;
  logic                  Mem_En;
  logic [BYTE_LEN-1:0]   Mem_Wen;
  logic [SYS_DWIDTH-1:0] Mem_Addr;
  logic [SYS_DWIDTH-1:0] Mem_Dout;
  logic [SYS_DWIDTH-1:0] Mem_Din;
  logic                  Computation_Start;
  logic                  Computation_Done;
  logic                  Busy;
  logic                  Timeout_Err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SYS_DWIDTH-1:0] bram [2**AWIDTH];
  logic [SYS_DWIDTH-1:0] ld_data [4];

  cgra_batch_ctrl #(
    .SYS_DWIDTH   (SYS_DWIDTH),
    .BYTE_LEN     (BYTE_LEN),
    .AWIDTH       (AWIDTH),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) dut (
    .Clk               (Clk),
    .Resetn            (Resetn),
    .Cfg_Start         (Cfg_Start),
    .Cfg_In_Words      (Cfg_In_Words),
    .Cfg_Out_Base      (Cfg_Out_Base),
    .Cfg_Out_Words     (Cfg_Out_Words),
    .In_Valid          (In_Valid),
    .In_Ready          (In_Ready),
    .In_Data           (In_Data),
    .Out_Valid         (Out_Valid),
    .Out_Ready         (Out_Ready),
    .Out_Data          (Out_Data),
    .Out_Last          (Out_Last),
    .Mem_En            (Mem_En),
    .Mem_Wen           (Mem_Wen),
    .Mem_Addr          (Mem_Addr),
    .Mem_Dout          (Mem_Dout),
    .Mem_Din           (Mem_Din),
    .Computation_Start (Computation_Start),
    .Computation_Done  (Computation_Done),
    .Busy              (Busy),
    .Timeout_Err       (Timeout_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial Mem_Din = '0;
  always @(posedge Clk) begin
    if (Mem_En && (Mem_Wen == 4'hF))
      bram[Mem_Addr[AWIDTH+1:2]] <= Mem_Dout;
    if (Mem_En && (Mem_Wen == 4'h0))
      Mem_Din <= bram[Mem_Addr[AWIDTH+1:2]];
  end

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input bit ok,
                       input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".In_Ready"},    In_Ready === 1'b0,          In_Ready,          1'b0);
    check({tag, ".Out_Valid"},   Out_Valid === 1'b0,         Out_Valid,         1'b0);
    check({tag, ".Out_Last"},    Out_Last === 1'b0,          Out_Last,          1'b0);
    check({tag, ".Mem_En"},      Mem_En === 1'b0,            Mem_En,            1'b0);
    check({tag, ".Mem_Wen"},     Mem_Wen === 4'h0,           Mem_Wen,           4'h0);
    check({tag, ".Mem_Addr"},    Mem_Addr === 32'h0,         Mem_Addr,          32'h0);
    check({tag, ".Mem_Dout"},    Mem_Dout === 32'h0,         Mem_Dout,          32'h0);
    check({tag, ".Start"},       Computation_Start === 1'b0, Computation_Start, 1'b0);
    check({tag, ".Busy"},        Busy === 1'b0,              Busy,              1'b0);
    check({tag, ".Timeout_Err"}, Timeout_Err === 1'b0,       Timeout_Err,       1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int issued;
    int got;
    bit stalled;
    bit finished;
    logic [SYS_DWIDTH-1:0] held;

    ld_data[0] = 32'h11;
    ld_data[1] = 32'h22;
    ld_data[2] = 32'h33;
    ld_data[3] = 32'h44;
    for (int i = 0; i < 2**AWIDTH; i++) bram[i] = '0;
    bram[4094] = 32'hAAAA_0001;
    bram[4095] = 32'hAAAA_0002;
    for (int i = 0; i < 6; i++) bram[8 + i] = 32'h100 + i;

    Resetn = 1'b1;
    Cfg_Start = 0; Cfg_In_Words = '0; Cfg_Out_Base = '0; Cfg_Out_Words = '0;
    In_Valid = 0; In_Data = '0; Out_Ready = 0; Computation_Done = 0;

    #2 Resetn = 1'b0;
    #1;
    check_all_zero("reset");
    step; step;
    Resetn = 1'b1;
    step;

    Cfg_Start = 1; Cfg_In_Words = 4; Cfg_Out_Base = 12'd4094; Cfg_Out_Words = 4;
    In_Valid = 1; In_Data = ld_data[0];
    #1;
    check("idle.In_Ready", In_Ready === 1'b0, In_Ready, 1'b0);
    check("idle.Busy", Busy === 1'b0, Busy, 1'b0);
    step;
    Cfg_Start = 0;
    for (int k = 0; k < 4; k++) begin
      In_Data = ld_data[k];
      #1;
      check("load.In_Ready", In_Ready === 1'b1, In_Ready, 1'b1);
      check("load.Mem_En", Mem_En === 1'b1, Mem_En, 1'b1);
      check("load.Mem_Wen", Mem_Wen === 4'hF, Mem_Wen, 4'hF);
      check("load.Mem_Addr", Mem_Addr === 32'(4 * k), Mem_Addr, 32'(4 * k));
      check("load.Mem_Dout", Mem_Dout === ld_data[k], Mem_Dout, ld_data[k]);
      check("load.Start", Computation_Start === 1'b0, Computation_Start, 1'b0);
      step;
    end
    In_Valid = 0;
    #1;
    check("run.Start_rise", Computation_Start === 1'b1, Computation_Start, 1'b1);
    check("run.Mem_En", Mem_En === 1'b0, Mem_En, 1'b0);
    check("run.In_Ready", In_Ready === 1'b0, In_Ready, 1'b0);

    for (int i = 1; i <= 10; i++) begin
      step;
      #1;
      check("run.Start_held", Computation_Start === 1'b1, Computation_Start, 1'b1);
    end
    Computation_Done = 1;
    step;
    #1;
    check("release.Start_fall", Computation_Start === 1'b0, Computation_Start, 1'b0);
    check("release.Busy", Busy === 1'b1, Busy, 1'b1);
    check("release.Mem_En", Mem_En === 1'b0, Mem_En, 1'b0);
    step; step; step;
    Computation_Done = 0;
    #1;
    check("release.no_read", Mem_En === 1'b0, Mem_En, 1'b0);
    step;

    Out_Ready = 1;
    #1;
    check("u0.Mem_En", Mem_En === 1'b1, Mem_En, 1'b1);
    check("u0.Mem_Wen", Mem_Wen === 4'h0, Mem_Wen, 4'h0);
    check("u0.Mem_Addr", Mem_Addr === 32'h3FF8, Mem_Addr, 32'h3FF8);
    check("u0.Out_Valid", Out_Valid === 1'b0, Out_Valid, 1'b0);
    step; #1;
    check("u1.Mem_Addr", Mem_Addr === 32'h3FFC, Mem_Addr, 32'h3FFC);
    check("u1.Out_Valid", Out_Valid === 1'b0, Out_Valid, 1'b0);
    step; #1;
    check("u2.Mem_Addr", Mem_Addr === 32'h0, Mem_Addr, 32'h0);
    check("u2.Out_Valid", Out_Valid === 1'b1, Out_Valid, 1'b1);
    check("u2.Out_Data", Out_Data === 32'hAAAA_0001, Out_Data, 32'hAAAA_0001);
    check("u2.Out_Last", Out_Last === 1'b0, Out_Last, 1'b0);
    step; #1;
    check("u3.Mem_Addr", Mem_Addr === 32'h4, Mem_Addr, 32'h4);
    check("u3.Out_Data", Out_Data === 32'hAAAA_0002, Out_Data, 32'hAAAA_0002);
    check("u3.Out_Last", Out_Last === 1'b0, Out_Last, 1'b0);
    step; #1;
    check("u4.Mem_En", Mem_En === 1'b0, Mem_En, 1'b0);
    check("u4.Out_Valid", Out_Valid === 1'b1, Out_Valid, 1'b1);
    check("u4.Out_Data", Out_Data === 32'h11, Out_Data, 32'h11);
    check("u4.Out_Last", Out_Last === 1'b0, Out_Last, 1'b0);
    step; #1;
    check("u5.Out_Data", Out_Data === 32'h22, Out_Data, 32'h22);
    check("u5.Out_Last", Out_Last === 1'b1, Out_Last, 1'b1);
    step; #1;
    check("u6.Busy", Busy === 1'b0, Busy, 1'b0);
    check("u6.Out_Valid", Out_Valid === 1'b0, Out_Valid, 1'b0);

    step;
    Cfg_Start = 1; Cfg_In_Words = 0; Cfg_Out_Base = 12'd8; Cfg_Out_Words = 6;
    Computation_Done = 1; Out_Ready = 0;
    #1;
    check("bp.idle_Busy", Busy === 1'b0, Busy, 1'b0);
    step;
    Cfg_Start = 0;
    #1;
    check("bp.run_Start", Computation_Start === 1'b1, Computation_Start, 1'b1);
    check("bp.run_no_write", Mem_En === 1'b0, Mem_En, 1'b0);
    step;
    Computation_Done = 0;
    #1;
    check("bp.release_Start", Computation_Start === 1'b0, Computation_Start, 1'b0);
    step;
    issued = 0; got = 0; stalled = 0; held = '0; finished = 0;
    for (int c = 0; c < 60; c++) begin
      Out_Ready = ((c % 4) == 0) || ((c % 4) == 3);
      #1;
      if (!Busy) begin
        finished = 1;
        break;
      end
      if (Mem_En) begin
        check("bp.Mem_Wen", Mem_Wen === 4'h0, Mem_Wen, 4'h0);
        check("bp.Mem_Addr", Mem_Addr === 32'(4 * (8 + issued)), Mem_Addr, 32'(4 * (8 + issued)));
        issued++;
      end
      if (Out_Valid) begin
        if (stalled) check("bp.stable", Out_Data === held, Out_Data, held);
        check("bp.Out_Data", Out_Data === 32'(32'h100 + got), Out_Data, 32'(32'h100 + got));
        check("bp.Out_Last", Out_Last === (got == 5), Out_Last, (got == 5));
        if (Out_Ready) got++;
      end
      stalled = Out_Valid && !Out_Ready;
      held    = Out_Data;
      check("bp.outstanding_le2", (issued - got) <= 2, issued - got, 2);
      step;
    end
    check("bp.finished", finished === 1'b1, finished, 1'b1);
    check("bp.beats", got == 6, got, 6);
    check("bp.reads", issued == 6, issued, 6);

    Out_Ready = 0;
    Cfg_Start = 1; Cfg_In_Words = 0; Cfg_Out_Words = 1; Computation_Done = 0;
    step;
    Cfg_Start = 0;
    for (int i = 0; i < DONE_TIMEOUT; i++) begin
      #1;
      check("to.Start_high", Computation_Start === 1'b1, Computation_Start, 1'b1);
      check("to.Err_low", Timeout_Err === 1'b0, Timeout_Err, 1'b0);
      step;
    end
    #1;
    check("to.Start_fall", Computation_Start === 1'b0, Computation_Start, 1'b0);
    check("to.Timeout_Err", Timeout_Err === 1'b1, Timeout_Err, 1'b1);
    check("to.Busy", Busy === 1'b0, Busy, 1'b0);
    check("to.no_unload", Mem_En === 1'b0, Mem_En, 1'b0);
    step;
    Cfg_Start = 1; Cfg_Out_Words = 0; Computation_Done = 1;
    #1;
    check("to.Err_sticky", Timeout_Err === 1'b1, Timeout_Err, 1'b1);
    step;
    Cfg_Start = 0;
    #1;
    check("to.Err_cleared", Timeout_Err === 1'b0, Timeout_Err, 1'b0);
    check("to.restart_Start", Computation_Start === 1'b1, Computation_Start, 1'b1);
    step;
    Computation_Done = 0;
    step;
    #1;
    check("to.back_idle", Busy === 1'b0, Busy, 1'b0);

    step;
    Cfg_Start = 1; Cfg_In_Words = 0; Cfg_Out_Base = 12'd0; Cfg_Out_Words = 4;
    Computation_Done = 1; Out_Ready = 0;
    step;
    Cfg_Start = 0;
    step;
    Computation_Done = 0;
    step; step; step;
    #1;
    check("rst.in_unload", Out_Valid === 1'b1, Out_Valid, 1'b1);
    Resetn = 1'b0;
    #1;
    check_all_zero("rst.mid");
    step;
    #1;
    check("rst.held_Mem_En", Mem_En === 1'b0, Mem_En, 1'b0);
    step;
    Resetn = 1'b1;
    step;
    Cfg_Start = 1; Cfg_In_Words = 0; Cfg_Out_Words = 0; Computation_Done = 0;
    #1;
    check("rst.idle_Busy", Busy === 1'b0, Busy, 1'b0);
    step;
    Cfg_Start = 0;
    #1;
    check("rst.run_Start", Computation_Start === 1'b1, Computation_Start, 1'b1);
    check("rst.run_Busy", Busy === 1'b1, Busy, 1'b1);
    Computation_Done = 1;
    step;
    #1;
    check("rst.release_Start", Computation_Start === 1'b0, Computation_Start, 1'b0);
    check("rst.release_Busy", Busy === 1'b1, Busy, 1'b1);
    Computation_Done = 0;
    step;
    #1;
    check("rst.end_Busy", Busy === 1'b0, Busy, 1'b0);
    check("rst.end_Mem_En", Mem_En === 1'b0, Mem_En, 1'b0);
    check("rst.end_Out_Valid", Out_Valid === 1'b0, Out_Valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cgra_batch_ctrl.md
Name: cgra_batch_ctrl

Overview:
- Host-side sequencer that sits directly upstream of the CGRA top and drives its start/done handshake.
- Streams an input batch into the data BRAM through a BRAM-style port, then raises Computation_Start and waits for Computation_Done.
- After the handshake completes, reads the result window back out of the same BRAM as a valid/ready stream.
- Replaces software polling of the start/done flags.

Parameters:
SYS_DWIDTH, 32, data and byte-address width of the BRAM port
BYTE_LEN, 4, bytes per word; width of Mem_Wen; address step per word
AWIDTH, 12, word-index width (BRAM depth = 2**AWIDTH words)
DONE_TIMEOUT, 65535, maximum cycles in RUN before abort

Ports:
Clk  in  1  system clock; everything sampled on the rising edge
Resetn  in  1  asynchronous active-low reset
Cfg_Start  in  1  one-cycle request to begin a batch; ignored while Busy
Cfg_In_Words  in  AWIDTH+1  number of words to load, starting at word 0
Cfg_Out_Base  in  AWIDTH  first word index of the result window
Cfg_Out_Words  in  AWIDTH+1  number of result words to unload
In_Valid  in  1  input stream valid
In_Ready  out  1  input stream ready
In_Data  in  SYS_DWIDTH  input word
Out_Valid  out  1  result stream valid
Out_Ready  in  1  result stream ready
Out_Data  out  SYS_DWIDTH  result word
Out_Last  out  1  high with the final result word
Mem_En  out  1  BRAM enable
Mem_Wen  out  BYTE_LEN  BRAM byte write enables (all-ones or zero)
Mem_Addr  out  SYS_DWIDTH  BRAM byte address = word index * BYTE_LEN
Mem_Dout  out  SYS_DWIDTH  write data to BRAM
Mem_Din  in  SYS_DWIDTH  read data from BRAM; valid exactly 1 cycle after a read
Computation_Start  out  1  to CGRA; level signal
Computation_Done  in  1  from CGRA; level signal
Busy  out  1  high in every state except IDLE
Timeout_Err  out  1  sticky; set on abort, cleared by the next accepted Cfg_Start

Behaviour:
- Reset: state IDLE. All outputs 0: In_Ready, Out_Valid, Out_Last, Mem_En, Mem_Wen, Mem_Addr, Mem_Dout, Computation_Start, Busy, Timeout_Err. Counters and the FIFO are cleared.
- Reset asserted mid-operation aborts the batch immediately. No further BRAM access occurs; Computation_Start drops asynchronously.
- Cfg_* inputs are latched on the accepting Cfg_Start.
- IDLE: on Cfg_Start, go to LOAD; if Cfg_In_Words == 0, go directly to RUN.
- LOAD:
  - In_Ready = 1.
  - Each In_Valid & In_Ready beat writes the word in the same cycle: Mem_En = 1, Mem_Wen = all-ones, Mem_Addr = idx * BYTE_LEN.
  - idx increments per beat; after beat Cfg_In_Words, go to RUN.
  - Bubbles on In_Valid are allowed; no write occurs in a bubble cycle.
- RUN:
  - Computation_Start = 1; timeout counter runs.
  - Done == 1 sampled: go to RELEASE.
  - Counter reaches DONE_TIMEOUT: set Timeout_Err, drop Start, go to IDLE (no unload).
  - Done already high on entry counts as seen.
- RELEASE: Computation_Start = 0; wait for Done == 0. Then go to UNLOAD, or to IDLE if Cfg_Out_Words == 0.
- UNLOAD:
  - Reads are issued at Cfg_Out_Base + k, k = 0 .. Cfg_Out_Words-1.
  - The word index wraps modulo 2**AWIDTH.
  - Mem_En = 1, Mem_Wen = 0 on each read.
  - Each Mem_Din is captured one cycle later into a 2-entry FIFO.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2. This sustains 1 word/cycle when Out_Ready is held high and never overflows the FIFO.
  - Out_* is driven from the FIFO head. Out_Last is high when the head is word Cfg_Out_Words-1.
  - When the Last beat is accepted, go to IDLE.
- Out_Data must hold stable while Out_Valid & !Out_Ready.
- In states other than LOAD and UNLOAD, Mem_En = 0.

Decomposition:
- Shared package cgra_batch_pkg holds:
  - state enum: IDLE, LOAD, RUN, RELEASE, UNLOAD
  - function word-to-byte-address (shift by log2(BYTE_LEN))
- Sub-module cgra_fifo2: 2-entry synchronous FIFO with valid/ready on both sides, same clock and reset.

Test Plan:
- Load 4 words (0x11, 0x22, 0x33, 0x44), In_Valid always high -> 4 write cycles at byte addresses 0, 4, 8, 12 with Wen = 4'hF. Start rises the cycle after the 4th write.
- Model asserts Done 10 cycles after Start -> Start falls the cycle after Done is sampled. Done is then dropped 3 cycles later -> first read issued the cycle after Done is sampled low.
- Out_Base = 2**AWIDTH-2, Out_Words = 4, Out_Ready constant 1 -> reads at words 4094, 4095, 0, 1. Output arrives back-to-back with Last on the 4th beat.
- Out_Ready toggled 1,0,0,1,... over 6 words -> no dropped or duplicated data, Out_Data stable while stalled, Mem_En never issues a 3rd outstanding read.
- Done held low with DONE_TIMEOUT = 20 -> Start falls after 20 RUN cycles, Timeout_Err = 1, Busy = 0. The next Cfg_Start clears Timeout_Err.
- Resetn pulsed low during UNLOAD -> all outputs 0 immediately. After release, a Cfg_Start with In_Words = 0 and Out_Words = 0 runs only RUN and RELEASE, then returns to IDLE.
